// File: rtl/mem_byte_initiator.sv
// Word load/store initiator: splits one aligned word request into big-endian byte
// transactions on a valid/grant memory port and reassembles load bytes into a word.
module mem_byte_initiator #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA          = 32,
  parameter int BPI           = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA-1:0]          req_wdata,
  output logic                     req_ready,
  output logic                     stall,
  output logic                     resp_valid,
  output logic [DATA-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [7:0]               mem_rdata
);

  localparam int KW = (BPI > 1) ? $clog2(BPI) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     write_q, write_d;
  logic                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA-1:0]          wdata_q, wdata_d;
  logic [DATA-1:0]          asm_q, asm_d;
  logic [DATA-1:0]          rdata_q, rdata_d;
  logic [TW-1:0]            tmo_q, tmo_d;

  logic                     last_byte;
  logic                     tmo_hit;
  logic                     misaligned;
  logic [DATA-1:0]          wdata_sh;
  logic [DATA-1:0]          rbyte_pos;
  logic [DATA-1:0]          rbyte_mask;
  logic [DATA-1:0]          asm_upd;

  assign last_byte  = (k_q == KW'(BPI - 1));
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
  assign misaligned = |req_addr[KW-1:0];

  // Byte k sits k bytes below the MSB, so shifting by 8k brings it to the top.
  assign wdata_sh   = wdata_q << {k_q, 3'b000};
  assign rbyte_pos  = {mem_rdata, {(DATA-8){1'b0}}} >> {k_q, 3'b000};
  assign rbyte_mask = {8'hFF, {(DATA-8){1'b0}}} >> {k_q, 3'b000};
  assign asm_upd    = (asm_q & ~rbyte_mask) | rbyte_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = '0;
          err_d   = misaligned;
          state_d = misaligned ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (!write_q) begin
            state_d = WAIT_R;
          end else if (last_byte) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          asm_d = asm_upd;
          if (last_byte) begin
            rdata_d = asm_upd;
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The watchdog restarts on any state change and on every memory handshake.
    if ((state_d != state_q) || ((state_q == ISSUE) && mem_gnt) ||
        ((state_q == WAIT_R) && mem_rvalid)) begin
      tmo_d = '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT_R)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_err   = (state_q == DONE) & err_q;
  assign resp_rdata = rdata_q;
  assign mem_req    = (state_q == ISSUE);
  assign mem_we     = mem_req & write_q;
  assign mem_addr   = mem_req ? (addr_q + ADDRESS_WIDTH'(k_q)) : '0;
  assign mem_wdata  = mem_req ? wdata_sh[DATA-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Randomized bench for mem_byte_initiator with a byte-addressed memory model
// and a word-level expectation of every transaction.
module tb_mem_byte_initiator;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BPI = 4;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, stall, resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_byte_initiator #(
    .ADDRESS_WIDTH(AW), .DATA(DW), .BPI(BPI), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  mem_m [bit [31:0]];
  logic [31:0] hs_addr [$];
  logic        hs_we   [$];
  logic [7:0]  hs_wd   [$];
  int          resp_cyc;
  logic        resp_err_s;
  logic [31:0] resp_rd_s;
  int          stall_bad;
  int          req_cycles;
  logic [31:0] hold_rdata;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 8'h00;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int i = 0; i < BPI; i++) w = (w << 8) | 32'(rd_byte(a + 32'(i)));
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_ready"}, req_ready, 1);
    chk_val({tag, "_stall"}, stall, 0);
    chk_val({tag, "_rvalid"}, resp_valid, 0);
    chk_val({tag, "_rerr"}, resp_err, 0);
    chk_val({tag, "_rdata"}, resp_rdata, 0);
    chk_val({tag, "_mreq"}, mem_req, 0);
    chk_val({tag, "_mwe"}, mem_we, 0);
    chk_val({tag, "_maddr"}, mem_addr, 0);
    chk_val({tag, "_mwd"}, mem_wdata, 0);
  endtask

  // Presents one request and plays the memory side until the response or budget.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int gmax, input int rmax, input bit no_gnt,
                         input int rst_byte, input int budget);
    int   gwait, rwait, nrd;
    bit   rd_pend;
    logic [31:0] rd_addr;
    hs_addr.delete(); hs_we.delete(); hs_wd.delete();
    resp_cyc = -1; resp_err_s = 0; resp_rd_s = '0;
    stall_bad = 0; req_cycles = 0;
    gwait = -1; rwait = 0; nrd = 0; rd_pend = 0; rd_addr = '0;
    chk_val("accept_ready", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 8'($urandom);
      if (resp_valid) begin
        resp_cyc = cyc; resp_err_s = resp_err; resp_rd_s = resp_rdata;
        if (!stall) stall_bad++;
        break;
      end
      if (!stall) stall_bad++;
      if (mem_req) req_cycles++;
      if (rst_byte >= 0 && rd_pend && nrd == rst_byte + 1) begin
        reset = 1;
        step();
        reset = 0;
        chk_reset_outputs("rst_mid");
        resp_cyc = -2;
        step();
        chk_val("rst_no_resp", resp_valid, 0);
        return;
      end
      if (rd_pend) begin
        if (rwait == 0) begin
          mem_rvalid = 1; mem_rdata = rd_byte(rd_addr); rd_pend = 0;
        end else rwait--;
      end else if (mem_req && !no_gnt) begin
        if (gwait < 0) gwait = int'($urandom_range(gmax, 0));
        if (gwait == 0) begin
          mem_gnt = 1; gwait = -1;
          hs_addr.push_back(mem_addr); hs_we.push_back(mem_we); hs_wd.push_back(mem_wdata);
          if (mem_we) mem_m[mem_addr] = mem_wdata;
          else begin
            rd_pend = 1; rwait = int'($urandom_range(rmax, 0)); rd_addr = mem_addr; nrd++;
          end
        end else gwait--;
      end
      step();
    end
    mem_gnt = 0; mem_rvalid = 0;
  endtask

  task automatic chk_hs(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd);
    chk_val({tag, "_nhs"}, hs_addr.size(), BPI);
    for (int i = 0; i < hs_addr.size() && i < BPI; i++) begin
      chk_val({tag, "_hsaddr"}, hs_addr[i], addr + 32'(i));
      chk_val({tag, "_hswe"}, hs_we[i], wr);
      if (wr) chk_val({tag, "_hswd"}, hs_wd[i], (wd >> (8 * (BPI - 1 - i))) & 32'hFF);
    end
  endtask

  task automatic chk_after(input string tag);
    step();
    chk_val({tag, "_pulse"}, resp_valid, 0);
    chk_val({tag, "_idle_ready"}, req_ready, 1);
    chk_val({tag, "_idle_stall"}, stall, 0);
  endtask

  initial begin
    logic [31:0] a, w, exp_w;
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    hold_rdata = '0;
    step(); step();
    chk_reset_outputs("reset");
    reset = 0;
    step();

    run_txn(1, 32'h100, 32'hDEADBEEF, 0, 0, 0, -1, 50);
    chk_val("st_cyc", resp_cyc, 5);
    chk_val("st_err", resp_err_s, 0);
    chk_val("st_rdata_hold", resp_rd_s, hold_rdata);
    chk_val("st_stall", stall_bad, 0);
    chk_hs("st", 1, 32'h100, 32'hDEADBEEF);
    chk_after("st");

    mem_m[32'h200] = 8'h11; mem_m[32'h201] = 8'h22;
    mem_m[32'h202] = 8'h33; mem_m[32'h203] = 8'h44;
    run_txn(0, 32'h200, '0, 0, 0, 0, -1, 50);
    chk_val("ld_cyc", resp_cyc, 9);
    chk_val("ld_err", resp_err_s, 0);
    chk_val("ld_data", resp_rd_s, 32'h11223344);
    chk_hs("ld", 0, 32'h200, '0);
    hold_rdata = 32'h11223344;
    chk_after("ld");

    for (int t = 0; t < 8; t++) begin
      a = $urandom & 32'hFFFF_FFFC;
      w = $urandom;
      run_txn(1, a, w, 5, 5, 0, -1, 200);
      chk_val("rst_err", resp_err_s, 0);
      chk_val("rst_stall", stall_bad, 0);
      chk_hs("rst", 1, a, w);
      chk_val("rst_hold", resp_rd_s, hold_rdata);
      step();
      if (t % 2 == 0) begin
        for (int i = 0; i < BPI; i++) mem_m[a + 32'(i)] = 8'($urandom);
      end
      exp_w = model_word(a);
      run_txn(0, a, '0, 5, 5, 0, -1, 200);
      chk_val("rld_err", resp_err_s, 0);
      chk_val("rld_data", resp_rd_s, exp_w);
      chk_val("rld_stall", stall_bad, 0);
      chk_hs("rld", 0, a, '0);
      if (t % 2 == 1) chk_val("rld_readback", resp_rd_s, w);
      hold_rdata = exp_w;
      step();
    end

    run_txn(1, 32'h102, 32'hCAFEF00D, 0, 0, 0, -1, 20);
    chk_val("mis_st_cyc", resp_cyc, 1);
    chk_val("mis_st_err", resp_err_s, 1);
    chk_val("mis_st_nhs", hs_addr.size(), 0);
    chk_val("mis_st_hold", resp_rd_s, hold_rdata);
    chk_after("mis_st");

    run_txn(0, 32'h203, '0, 0, 0, 0, -1, 20);
    chk_val("mis_ld_err", resp_err_s, 1);
    chk_val("mis_ld_nhs", hs_addr.size(), 0);
    chk_val("mis_ld_hold", resp_rd_s, hold_rdata);
    step();

    run_txn(0, 32'h300, '0, 0, 0, 1, -1, 400);
    chk_val("tmo_cyc", resp_cyc, 1 + TMO);
    chk_val("tmo_err", resp_err_s, 1);
    chk_val("tmo_req_cycles", req_cycles, TMO);
    chk_val("tmo_hold", resp_rd_s, hold_rdata);
    chk_after("tmo");

    run_txn(0, 32'h200, '0, 0, 0, 0, 2, 50);
    chk_val("rst_mid_flag", resp_cyc, -2);
    hold_rdata = '0;
    run_txn(0, 32'h200, '0, 0, 0, 0, -1, 50);
    chk_val("post_rst_cyc", resp_cyc, 9);
    chk_val("post_rst_err", resp_err_s, 0);
    chk_val("post_rst_data", resp_rd_s, 32'h11223344);
    chk_after("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
